// File: rtl/alu_issue_queue.sv
// Command FIFO feeding an external combinational ALU, with a registered
// valid/ready result stage. Results leave in the same order commands arrived.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    output logic [1:0]    alu_op,
    output logic [7:0]    alu_i0,
    output logic [7:0]    alu_i1,
    input  logic [7:0]    alu_o,
    input  logic          alu_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_result,
    output logic          out_cout,
    output logic [1:0]    out_op,
    output logic [AW:0]   count
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    // Handshake rules: a transfer happens on a rising edge where valid and
    // ready are both high; in_ready depends only on registered occupancy.
    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_out_valid;
    logic [7:0]    r_out_result;
    logic          r_out_cout;
    logic [1:0]    r_out_op;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [17:0]   w_head;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != LP_DEPTH);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = ~w_empty & (~r_out_valid | out_ready);
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        alu_op = 2'b00;
        alu_i0 = 8'h00;
        alu_i1 = 8'h00;
        if (!w_empty) begin
            alu_op = w_head[17:16];
            alu_i0 = w_head[15:8];
            alu_i1 = w_head[7:0];
        end
    end

    // Storage is intentionally left uninitialised; occupancy alone marks validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= 8'h00;
            r_out_cout   <= 1'b0;
            r_out_op     <= 2'b00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_out_valid  <= 1'b1;
                r_out_result <= alu_o;
                r_out_op     <= alu_op;
                r_out_cout   <= alu_op[1] ? 1'b0 : alu_cout;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_cout   = r_out_cout;
    assign out_op     = r_out_op;
    assign count      = r_count;

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Command queue and result stage that sits directly upstream and downstream of the 8-bit `alu` datapath. It buffers incoming (op, a, b) commands in a FIFO.
- The head command drives the combinational ALU. The ALU result is captured into an output register with a valid/ready handshake.
- It decouples the producer and the consumer from the ALU and preserves command order.

Parameters:
- DEPTH, 4, number of FIFO command entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a command is presented.
- in_ready  out  1  the queue can accept a command.
- in_op  in  2  00 add, 01 sub (a-b), 10 and, 11 or.
- in_a  in  8  operand a.
- in_b  in  8  operand b.
- alu_op  out  2  to ALU `op`.
- alu_i0  out  8  to ALU `i0` (operand a).
- alu_i1  out  8  to ALU `i1` (operand b).
- alu_o  in  8  from ALU `o`.
- alu_cout  in  1  from ALU `cout`.
- out_valid  out  1  the result register holds a result.
- out_ready  in  1  the consumer takes the result.
- out_result  out  8  result.
- out_cout  out  1  carry out for add; not-borrow for sub; 0 for and/or.
- out_op  out  2  op that produced out_result.
- count  out  AW+1  FIFO occupancy; excludes the output register.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr=rd_ptr=0 and count=0.
  - out_valid=0, out_result=0, out_cout=0, out_op=0.
  - The FIFO storage is not cleared.
  - Reset overrides every simultaneous push and pop. Commands in flight are discarded.
- Push:
  - push = in_valid & in_ready.
  - in_ready = (count != DEPTH). It depends on registered state only and has no same-cycle pop bypass.
  - On push, {in_op, in_a, in_b} is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - in_valid while in_ready=0 is ignored; no state changes.
- ALU drive:
  - When count>0, {alu_op, alu_i0, alu_i1} = head entry at rd_ptr (combinational from storage).
  - When count=0 they are driven to all zeros.
- Pop / capture:
  - pop = (count>0) & (~out_valid | out_ready).
  - On pop: out_result<=alu_o and out_op<=alu_op. out_cout<=alu_cout when alu_op[1]=0, else 0. out_valid<=1. rd_ptr increments modulo DEPTH.
- Output retire:
  - out_ready & out_valid with no pop in the same cycle gives out_valid<=0. out_result, out_cout and out_op hold their values.
- Hold: while out_valid=1 and out_ready=0, the output register and head entry are unchanged. The ALU inputs stay stable.
- Count: push without pop gives +1; pop without push gives -1; push and pop together leave count unchanged.
- Latency:
  - A command pushed at edge E0 into an empty queue with an empty output register is at the head after E0.
  - It is captured at edge E1, so out_valid=1 in the cycle after E1.
  - Throughput is one command per cycle when out_ready=1 continuously.
- Capacity: DEPTH+1 commands can be outstanding (DEPTH in the FIFO plus 1 in the output register).
- Arithmetic is the ALU's. Sub computes a+~b+1, so cout=1 means a>=b unsigned. All results wrap modulo 256.
- Wrap-around: both pointers wrap DEPTH-1 -> 0. Full is count==DEPTH and empty is count==0; pointer equality is never used alone.
- Ordering: results appear strictly in push order with no loss or duplication.

Test Plan:
- Reset, then push add a=0x7F, b=0x01 with out_ready=1 -> out_valid=1 two edges after the push; out_result=0x80, out_cout=0, out_op=00; count returns to 0.
- Push sub 0x05-0x07, then sub 0x07-0x05 back-to-back -> results 0xFE/cout 0, then 0x02/cout 1, in that order on consecutive cycles.
- Push and 0xF0,0x3C, then or 0xF0,0x3C -> 0x30/cout 0, then 0xFC/cout 0.
- Hold out_ready=0 and push 6 commands every cycle -> 5 accepted; in_ready=0 once count=4 and out_valid=1. Then out_ready=1 -> all 5 drain in order, one per cycle, and count reaches 0.
- Sustain push/pop for 10 commands with out_ready toggling 1,0 -> pointers wrap, and all 10 results are in order and correct against a reference model.
- Assert rst for 1 cycle with 3 commands queued and out_valid=1 -> the next cycle has count=0, out_valid=0, out_result=0, in_ready=1, and no stale results appear afterward.
